// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider:
// default operand width and the control FSM state encoding.
package seq_divider_pkg;

    // Default operand / result width in bits (legal range 8..64).
    localparam int DEFAULT_WIDTH = 32;

    // Control FSM states. DONE is a single-cycle result-valid state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step: shift the partial remainder left by
// one, bring in the next dividend bit, trial-subtract the divisor magnitude
// over WIDTH+1 bits and keep the difference when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    // Shift, trial-subtract and select the new partial remainder.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        diff_s    = shifted_s - {1'b0, dvs};
        if (diff_s[WIDTH] == 1'b0) begin
            q_bit   = 1'b1;
            rem_out = diff_s[WIDTH-1:0];
        end else begin
            q_bit   = 1'b0;
            rem_out = shifted_s[WIDTH-1:0];
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider. One restoring step per cycle on the
// operand magnitudes, followed by a sign fix-up cycle; a zero divisor skips
// the iteration and reports all-ones / dividend with div_by_zero set.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Conditional two's-complement negation used for sign conversion and fix-up.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] dvd_r;       // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs_r;       // divisor magnitude
    logic [WIDTH-1:0] raw_dvd_r;   // dividend as presented, for the zero-divisor result
    logic [WIDTH-1:0] rem_r;       // partial remainder
    logic [WIDTH-1:0] quo_r;       // quotient magnitude being assembled
    logic [CNT_W-1:0] cnt_r;       // completed iteration steps
    logic             neg_q_r;     // quotient must be negated at fix-up
    logic             neg_rem_r;   // remainder must be negated at fix-up
    logic             dz_r;        // latched divisor was zero

    logic             accept_s;
    logic             last_s;
    logic             finish_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] fix_q_s;
    logic [WIDTH-1:0] fix_r_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dz_out_r;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[WIDTH-1]),
        .dvs     (dvs_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Control decode: acceptance, last-step detection and next-state logic.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (cnt_r == CNT_W'(WIDTH));
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_BUSY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dz_r || last_s) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s  = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture on accept and one restoring step per busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            raw_dvd_r <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
        end else if (accept_s) begin
            dvd_r     <= cond_neg(dividend, is_signed & dividend[WIDTH-1]);
            dvs_r     <= cond_neg(divisor, is_signed & divisor[WIDTH-1]);
            raw_dvd_r <= dividend;
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            neg_q_r   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_r <= is_signed & dividend[WIDTH-1];
            dz_r      <= (divisor == {WIDTH{1'b0}});
        end else if ((state_r == ST_BUSY) && !finish_s) begin
            rem_r     <= step_rem_s;
            quo_r     <= {quo_r[WIDTH-2:0], step_q_s};
            dvd_r     <= {dvd_r[WIDTH-2:0], 1'b0};
            cnt_r     <= cnt_r + CNT_W'(1);
        end else begin
            rem_r     <= rem_r;
            quo_r     <= quo_r;
            dvd_r     <= dvd_r;
            cnt_r     <= cnt_r;
        end
    end

    // Result fix-up: sign correction, or the fixed zero-divisor answer.
    // The most-negative / -1 case needs no special path: its magnitude
    // quotient negates back onto itself.
    always_comb begin
        fix_q_s = cond_neg(quo_r, neg_q_r);
        fix_r_s = cond_neg(rem_r, neg_rem_r);
        if (dz_r) begin
            fix_q_s = {WIDTH{1'b1}};
            fix_r_s = raw_dvd_r;
        end else begin
            fix_q_s = cond_neg(quo_r, neg_q_r);
            fix_r_s = cond_neg(rem_r, neg_rem_r);
        end
    end

    // Registered status and results; results change only on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dz_out_r    <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_BUSY);
            done_r <= (state_s == ST_DONE);
            if (finish_s) begin
                quotient_r  <= fix_q_s;
                remainder_r <= fix_r_s;
                dz_out_r    <= dz_r;
            end else begin
                quotient_r  <= quotient_r;
                remainder_r <= remainder_r;
                dz_out_r    <= dz_out_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dz_out_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH = 32) using a scoreboard queue:
// expected results are pushed on the accepting edge and popped on done.
module tb_seq_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t         sb[$];
    int unsigned  cyc;
    int           n_checks;
    int           n_errors;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dz;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference behaviour written from the arithmetic definition.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.due = 0;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = '0;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Result monitor: pops the scoreboard on done, otherwise checks results hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_q  = '0;
            last_r  = '0;
            last_dz = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.due));
                check("busy_low_at_done", 64'(busy), 64'd0);
            end
            last_q  = quotient;
            last_r  = remainder;
            last_dz = div_by_zero;
        end else begin
            if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_dz)
                check("result_hold", {quotient, remainder}, {last_q, last_r});
        end
    end

    // Drive one start at the current negedge; push expectation after acceptance.
    task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        e = model(sgn, a, b);
        @(posedge clk);
        #1;
        e.due = cyc + ((b == '0) ? 1 : W + 1);
        sb.push_back(e);
        check("busy_rise", 64'(busy), 64'd1);
        @(negedge clk);
        start     = 1'b0;
        is_signed = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        launch(sgn, a, b);
        wait_empty();
    endtask

    initial begin
        int n;
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFD);
        run_div(1'b0, 32'd3, 32'd10);

        // Start during busy is ignored.
        @(negedge clk);
        launch(1'b0, 32'd1000, 32'd33);
        repeat (8) @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd77; divisor = 32'd0;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignores_start", 64'(busy), 64'd1);
        wait_empty();

        // Back-to-back: new start in the DONE cycle.
        @(negedge clk);
        launch(1'b0, 32'd123456, 32'd789);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", 64'(done), 64'd1);
        launch(1'b1, 32'hFFFF_FF00, 32'd17);
        wait_empty();

        // Reset during busy aborts with no done pulse.
        @(negedge clk);
        launch(1'b0, 32'd999, 32'd4);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        check("abort_dz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_div(1'b0, 32'd9, 32'd3);

        // Random mix.
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = (i % 4 == 3) ? '0 : ($urandom >> $urandom_range(0, 28));
            run_div(1'($urandom_range(0, 1)), a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seq_divider
